// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : paddle_ctrl
// Brief    : Parametrised pong paddle controller. Synchronises the two
//            movement buttons, advances the paddle once per movement tick
//            with hold-to-accelerate behaviour, optionally tracks the ball
//            for a CPU player, clamps the paddle to the playfield and
//            produces a registered draw flag for the pixel mux.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_ctrl #(
  parameter int COORD_W    = 6,
  parameter int X_LOC      = 0,
  parameter int PADDLE_W   = 2,
  parameter int PADDLE_H   = 6,
  parameter int Y_MIN      = 6,
  parameter int Y_MAX      = 28,
  parameter int Y_INIT     = 6,
  parameter int STEP_DIV   = 100,
  parameter int FAST_AFTER = 8,
  parameter int DEADBAND   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_btn_down,
  input  logic               i_btn_up,
  input  logic               i_auto_en,
  input  logic [COORD_W-1:0] i_ball_y,
  input  logic [COORD_W-1:0] i_counter_x,
  input  logic [COORD_W-1:0] i_counter_y,
  output logic [COORD_W-1:0] o_location_y_axis,
  output logic               o_draw_padle,
  output logic               o_at_top,
  output logic               o_at_bottom,
  output logic               o_fast
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_tick_w = $clog2(STEP_DIV);
  // One spare code above FAST_AFTER so the increment never wraps.
  localparam int c_hold_w = $clog2(FAST_AFTER + 2);

  localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(STEP_DIV - 1);
  localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(FAST_AFTER);
  localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);

  // Coordinates are handled one bit wider so sums near the top of the
  // coordinate range never wrap.
  localparam logic [COORD_W:0] c_y_lo   = (COORD_W+1)'(Y_MIN);
  localparam logic [COORD_W:0] c_y_hi   = (COORD_W+1)'(Y_MAX - PADDLE_H);
  localparam logic [COORD_W:0] c_half   = (COORD_W+1)'(PADDLE_H / 2);
  localparam logic [COORD_W:0] c_db     = (COORD_W+1)'(DEADBAND);
  localparam logic [COORD_W:0] c_x_lo   = (COORD_W+1)'(X_LOC);
  localparam logic [COORD_W:0] c_pw     = (COORD_W+1)'(PADDLE_W);
  localparam logic [COORD_W:0] c_ph     = (COORD_W+1)'(PADDLE_H);
  localparam logic [COORD_W-1:0] c_y_init = COORD_W'(Y_INIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLOW = 2'd1,
    ST_FAST = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_DOWN = 2'd1,
    REQ_UP   = 2'd2
  } req_t;

  // --------------------------------------------------------------------------
  // Registers and wires
  // --------------------------------------------------------------------------
  logic                r_dn_meta;
  logic                r_dn_sync;
  logic                r_up_meta;
  logic                r_up_sync;
  logic [c_tick_w-1:0] r_tick_cnt;
  state_t              r_state;
  req_t                r_dir;
  logic [c_hold_w-1:0] r_hold;
  logic [COORD_W-1:0]  r_y;
  logic                r_fast;
  logic                r_draw;

  logic                w_tick;
  req_t                w_req;
  logic [COORD_W:0]    w_y_ext;
  logic [COORD_W:0]    w_center;
  logic [COORD_W:0]    w_ball;
  logic [c_hold_w-1:0] w_hold_inc;
  logic [COORD_W:0]    w_dx;
  logic [COORD_W:0]    w_dy;
  logic                w_in_window;

  // --------------------------------------------------------------------------
  // Move y by amt pixels in direction dir, saturating to the playfield.
  // --------------------------------------------------------------------------
  function automatic logic [COORD_W-1:0] f_step(
    input logic [COORD_W-1:0] y,
    input req_t               dir,
    input logic [1:0]         amt
  );
    logic [COORD_W:0] y_ext;
    logic [COORD_W:0] amt_ext;
    logic [COORD_W:0] res;
    y_ext   = {1'b0, y};
    amt_ext = {{(COORD_W-1){1'b0}}, amt};
    if (dir == REQ_DOWN) begin
      res = y_ext + amt_ext;
      if (res > c_y_hi) begin
        res = c_y_hi;
      end
    end else begin
      if (y_ext < (c_y_lo + amt_ext)) begin
        res = c_y_lo;
      end else begin
        res = y_ext - amt_ext;
      end
    end
    return res[COORD_W-1:0];
  endfunction

  // Two-flop synchronisers for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dn_meta <= 1'b0;
      r_dn_sync <= 1'b0;
      r_up_meta <= 1'b0;
      r_up_sync <= 1'b0;
    end else begin
      r_dn_meta <= i_btn_down;
      r_dn_sync <= r_dn_meta;
      r_up_meta <= i_btn_up;
      r_up_sync <= r_up_meta;
    end
  end

  // Movement tick divider: counts 0..STEP_DIV-1 and wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
    end
  end

  assign w_tick     = (r_tick_cnt == c_tick_last);
  assign w_y_ext    = {1'b0, r_y};
  assign w_center   = w_y_ext + c_half;
  assign w_ball     = {1'b0, i_ball_y};
  assign w_hold_inc = r_hold + c_hold_one;

  // Requested direction: ball tracking in auto mode, buttons otherwise.
  always_comb begin
    w_req = REQ_NONE;
    if (i_auto_en) begin
      if (w_ball > (w_center + c_db)) begin
        w_req = REQ_DOWN;
      end else if ((w_ball + c_db) < w_center) begin
        w_req = REQ_UP;
      end
    end else begin
      if (r_dn_sync && !r_up_sync) begin
        w_req = REQ_DOWN;
      end else if (r_up_sync && !r_dn_sync) begin
        w_req = REQ_UP;
      end
    end
  end

  // Movement FSM with registered position and fast flag; advances on ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dir   <= REQ_NONE;
      r_hold  <= '0;
      r_y     <= c_y_init;
      r_fast  <= 1'b0;
    end else if (w_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_req != REQ_NONE) begin
            r_state <= ST_SLOW;
            r_dir   <= w_req;
            r_hold  <= c_hold_one;
            r_y     <= f_step(r_y, w_req, 2'd1);
          end
        end
        ST_SLOW: begin
          if (w_req == REQ_NONE) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
          end else if (w_req != r_dir) begin
            r_dir  <= w_req;
            r_hold <= c_hold_one;
            r_y    <= f_step(r_y, w_req, 2'd1);
          end else begin
            r_y <= f_step(r_y, w_req, 2'd1);
            if (w_hold_inc >= c_hold_max) begin
              r_hold  <= c_hold_max;
              r_state <= ST_FAST;
              r_fast  <= 1'b1;
            end else begin
              r_hold <= w_hold_inc;
            end
          end
        end
        ST_FAST: begin
          if (w_req == REQ_NONE) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
            r_fast  <= 1'b0;
          end else if (w_req != r_dir) begin
            r_state <= ST_SLOW;
            r_dir   <= w_req;
            r_hold  <= c_hold_one;
            r_fast  <= 1'b0;
            r_y     <= f_step(r_y, w_req, 2'd1);
          end else begin
            r_y <= f_step(r_y, w_req, 2'd2);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_hold  <= '0;
          r_fast  <= 1'b0;
        end
      endcase
    end
  end

  // Offsets from the paddle origin; a scan position left of / above the
  // paddle wraps to a large value, so one unsigned compare per axis suffices.
  assign w_dx        = {1'b0, i_counter_x} - c_x_lo;
  assign w_dy        = {1'b0, i_counter_y} - w_y_ext;
  assign w_in_window = (w_dx < c_pw) && (w_dy < c_ph);

  // Registered draw flag, one cycle behind the scan coordinates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_draw <= 1'b0;
    end else begin
      r_draw <= w_in_window;
    end
  end

  assign o_location_y_axis = r_y;
  assign o_draw_padle      = r_draw;
  assign o_fast            = r_fast;
  assign o_at_top          = (w_y_ext == c_y_lo);
  assign o_at_bottom       = (w_y_ext == c_y_hi);

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_paddle_ctrl
// Brief    : Self-checking bench for paddle_ctrl (STEP_DIV=4, FAST_AFTER=3).
//            An integer reference model of the paddle rules is compared with
//            the DUT after every clock, plus directed boundary checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_paddle_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_down;
  logic       btn_up;
  logic       auto_en;
  logic [5:0] ball_y;
  logic [5:0] cx;
  logic [5:0] cy;
  logic [5:0] loc_y;
  logic       draw;
  logic       at_top;
  logic       at_bottom;
  logic       fast;

  int n_vec;
  int n_err;

  // Reference model state (plain integers)
  int m_y;
  int m_run;
  int m_dir;
  int m_cnt;
  int m_s1d, m_s2d, m_s1u, m_s2u;
  int m_draw;

  paddle_ctrl #(
    .STEP_DIV  (4),
    .FAST_AFTER(3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_btn_down       (btn_down),
    .i_btn_up         (btn_up),
    .i_auto_en        (auto_en),
    .i_ball_y         (ball_y),
    .i_counter_x      (cx),
    .i_counter_y      (cy),
    .o_location_y_axis(loc_y),
    .o_draw_padle     (draw),
    .o_at_top         (at_top),
    .o_at_bottom      (at_bottom),
    .o_fast           (fast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    assert (obs === 32'(exp)) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_y = 6; m_run = 0; m_dir = 0; m_cnt = 0;
    m_s1d = 0; m_s2d = 0; m_s1u = 0; m_s2u = 0;
    m_draw = 0;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".y"},      32'(loc_y),     m_y);
    chk({ctx, ".draw"},   32'(draw),      m_draw);
    chk({ctx, ".top"},    32'(at_top),    (m_y == 6)  ? 1 : 0);
    chk({ctx, ".bottom"}, 32'(at_bottom), (m_y == 22) ? 1 : 0);
    chk({ctx, ".fast"},   32'(fast),      (m_run >= 3) ? 1 : 0);
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare.
  task automatic cycle(input string ctx);
    int req;
    int step;
    int center;
    int draw_n;
    req = 0; step = 0; draw_n = 0;
    if (rst_n) begin
      draw_n = (int'(cx) <= 1 && int'(cy) >= m_y && int'(cy) <= m_y + 5) ? 1 : 0;
      if (m_cnt == 3) begin
        if (auto_en) begin
          center = m_y + 3;
          if (int'(ball_y) > center + 1)      req = 1;
          else if (int'(ball_y) + 1 < center) req = -1;
          else                                req = 0;
        end else begin
          req = m_s2d - m_s2u;
        end
        if (req == 0) begin
          m_run = 0;
          m_dir = 0;
        end else if (req == m_dir) begin
          step  = (m_run >= 3) ? 2 : 1;
          m_run = (m_run + 1 > 3) ? 3 : m_run + 1;
        end else begin
          step  = 1;
          m_run = 1;
          m_dir = req;
        end
        m_y = m_y + req * step;
        if (m_y < 6)  m_y = 6;
        if (m_y > 22) m_y = 22;
      end
      m_s2d = m_s1d; m_s1d = int'(btn_down);
      m_s2u = m_s1u; m_s1u = int'(btn_up);
      m_cnt = (m_cnt + 1) % 4;
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    m_draw = draw_n;
    check_all(ctx);
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge.
  task automatic async_reset(input string ctx);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({ctx, ".y_now"},    32'(loc_y),  6);
    chk({ctx, ".fast_now"}, 32'(fast),   0);
    chk({ctx, ".draw_now"}, 32'(draw),   0);
    chk({ctx, ".top_now"},  32'(at_top), 1);
    cycle({ctx, "_low"});
    cycle({ctx, "_low"});
    rst_n = 1'b1;
  endtask

  // Single short press of btn_down: exactly one pixel of movement.
  task automatic press_down_once(input string ctx);
    int y0;
    y0 = m_y;
    btn_down = 1'b1;
    for (int i = 0; i < 20 && m_y == y0; i++) cycle(ctx);
    chk({ctx, ".moved"}, 32'(loc_y), y0 + 1);
    btn_down = 1'b0;
    for (int i = 0; i < 8; i++) cycle(ctx);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    btn_down = 1'b0; btn_up = 1'b0; auto_en = 1'b0;
    ball_y = 6'd0; cx = 6'd63; cy = 6'd63;
    rst_n = 1'b1;
    model_reset();

    // Reset, with btn_down already held so the first tick moves the paddle
    #1 rst_n = 1'b0;
    #1;
    check_all("reset");
    btn_down = 1'b1;
    cycle("reset_hold");
    cycle("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("pre_tick");
    chk("first_tick_wait", 32'(loc_y), 6);
    cycle("first_tick");
    chk("first_tick_y", 32'(loc_y), 7);

    // Manual accelerate down to the bottom bound
    for (int i = 0; i < 60; i++) begin
      cycle("accel");
      if (m_y == 9 && m_cnt == 0) chk("accel_fast_at9", 32'(fast), 1);
    end
    chk("accel_end_y", 32'(loc_y), 22);
    chk("accel_end_bottom", 32'(at_bottom), 1);

    // Both buttons: no movement, back to idle
    btn_up = 1'b1;
    for (int i = 0; i < 12; i++) cycle("both");
    chk("both_y", 32'(loc_y), 22);
    chk("both_fast", 32'(fast), 0);

    // Re-accelerate against the bound, then reverse from FAST
    btn_up = 1'b0;
    for (int i = 0; i < 40 && m_run < 3; i++) cycle("refast");
    chk("refast_fast", 32'(fast), 1);
    btn_down = 1'b0; btn_up = 1'b1;
    for (int i = 0; i < 12 && m_y == 22; i++) cycle("reverse");
    chk("reverse_y", 32'(loc_y), 21);
    chk("reverse_fast", 32'(fast), 0);
    for (int i = 0; i < 24; i++) cycle("up_run");
    btn_up = 1'b0;

    // Auto tracking from y=6
    async_reset("rst_auto");
    auto_en = 1'b1;
    ball_y = 6'd10;
    for (int i = 0; i < 12; i++) cycle("auto_dead");
    chk("auto_dead_y", 32'(loc_y), 6);
    ball_y = 6'd20;
    for (int i = 0; i < 12; i++) cycle("auto_down");
    chk("auto_down_moved", 32'(loc_y > 6'd6), 1);
    ball_y = 6'd3;
    for (int i = 0; i < 40; i++) cycle("auto_up");
    chk("auto_up_y", 32'(loc_y), 6);
    chk("auto_up_top", 32'(at_top), 1);
    auto_en = 1'b0;

    // Step to y=10 one pixel at a time, then sweep the draw window
    for (int k = 0; k < 4; k++) press_down_once("nudge");
    chk("draw_y10", 32'(loc_y), 10);
    for (int x = 0; x <= 2; x++) begin
      for (int y = 9; y <= 16; y++) begin
        cx = 6'(x); cy = 6'(y);
        cycle("draw_sweep");
      end
    end
    cx = 6'd1; cy = 6'd15; cycle("draw_edge");
    chk("draw_in_corner", 32'(draw), 1);
    cx = 6'd0; cy = 6'd16; cycle("draw_edge");
    chk("draw_below", 32'(draw), 0);
    cx = 6'd2; cy = 6'd12; cycle("draw_edge");
    chk("draw_right", 32'(draw), 0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) btn_down = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) btn_up   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) auto_en  = ~auto_en;
      if ($urandom_range(0, 7)  == 0) ball_y   = 6'($urandom_range(0, 63));
      cx = 6'($urandom_range(0, 3));
      cy = 6'($urandom_range(0, 31));
      cycle("random");
    end

    // Async reset while in FAST at y=18
    btn_down = 1'b0; btn_up = 1'b0; auto_en = 1'b0; cx = 6'd63; cy = 6'd63;
    async_reset("rst_pre");
    press_down_once("to7");
    btn_down = 1'b1;
    for (int i = 0; i < 80 && m_y != 18; i++) cycle("to18");
    chk("pre_reset_y", 32'(loc_y), 18);
    chk("pre_reset_fast", 32'(fast), 1);
    async_reset("rst_fast");
    btn_down = 1'b0;
    for (int i = 0; i < 10; i++) cycle("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/paddle_ctrl.md
# paddle_ctrl

Parametrised paddle controller for the pong datapath. It replaces the fixed-size single-speed paddle with configurable geometry, coordinate width and playfield bounds. It adds button synchronisers, hold-to-accelerate movement and an automatic ball-tracking mode for a CPU-controlled player. One instance is used per player. Each instance feeds its paddle position to the ball/collision logic and its draw flag to the pixel mux.

## Interface
Parameters:
- COORD_W, 6: width of all coordinate ports and registers.
- X_LOC, 0: left column of the paddle.
- PADDLE_W, 2: paddle width in pixels (≥1).
- PADDLE_H, 6: paddle height in pixels (≥1).
- Y_MIN, 6: top-most allowed paddle row.
- Y_MAX, 28: one past the bottom-most allowed paddle pixel. Must satisfy Y_MAX − PADDLE_H ≥ Y_MIN.
- Y_INIT, 6: paddle row after reset. Must lie within [Y_MIN, Y_MAX−PADDLE_H].
- STEP_DIV, 100: clock cycles per movement tick (≥2).
- FAST_AFTER, 8: consecutive same-direction ticks before fast movement.
- DEADBAND, 1: auto-mode tolerance in pixels.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous, active-low reset.
- btn_down, in, 1: asynchronous button; increments y.
- btn_up, in, 1: asynchronous button; decrements y.
- auto_en, in, 1: 1 selects ball tracking; buttons are then ignored. Synchronous input.
- ball_y, in, COORD_W: ball row used in auto mode.
- counter_x, in, COORD_W: current scan column.
- counter_y, in, COORD_W: current scan row.
- location_y_axis, out, COORD_W: registered paddle top row.
- draw_padle, out, 1: registered; high when the scan position is inside the paddle.
- at_top, out, 1: location_y_axis == Y_MIN.
- at_bottom, out, 1: location_y_axis == Y_MAX−PADDLE_H.
- fast, out, 1: state is FAST.

## Operation
- Reset (rst=0, immediate) sets these values:
  - location_y_axis=Y_INIT, draw_padle=0, fast=0.
  - Tick counter=0, hold count=0, state IDLE, synchronisers 0.
  - at_top and at_bottom follow from Y_INIT.
- Buttons pass through 2-flop synchronisers before any use.
- Tick: a counter runs 0..STEP_DIV−1 and wraps. The tick strobe is high in the cycle the counter equals STEP_DIV−1.
- Request direction req is one of {NONE, DOWN, UP}:
  - Manual mode: down only → DOWN; up only → UP; both or neither → NONE.
  - Auto mode: center = y + PADDLE_H/2 (integer division), evaluated in COORD_W+1 bits.
    - ball_y > center+DEADBAND → DOWN.
    - ball_y + DEADBAND < center → UP.
    - Otherwise NONE.
- FSM states are IDLE, SLOW and FAST. It is evaluated only on tick cycles; the state is held between ticks.
  - IDLE: req≠NONE → SLOW, step 1, dir=req, hold=1.
  - SLOW: req==NONE → IDLE, no step.
    - req≠dir → SLOW, step 1 in the new direction, hold=1.
    - Otherwise step 1 and hold+1. When hold reaches FAST_AFTER → FAST.
  - FAST: req==dir → step 2. req≠dir and ≠NONE → SLOW, step 1 in the new direction, hold=1. req==NONE → IDLE.
  - Hold saturates at FAST_AFTER.
- Clamping: the new y is computed in COORD_W+1 bits and saturated to [Y_MIN, Y_MAX−PADDLE_H].
  - A step at a bound leaves y unchanged and does not change the FSM transition.
- auto_en toggling mid-move: treated as a change in req at the next tick. There is no special state.
- Draw region: X_LOC ≤ counter_x ≤ X_LOC+PADDLE_W−1 and y ≤ counter_y ≤ y+PADDLE_H−1.
  - Compared in COORD_W+1 bits, so no wrap-around at the top of the coordinate range.
  - Uses the current registered y.

## Timing
- draw_padle: 1-cycle latency from counter_x/counter_y.
- location_y_axis, at_top, at_bottom and fast update on the clock edge ending a tick cycle.
- Button latency: a press stable before edge n is visible to the FSM from cycle n+2. Movement occurs at the first tick at or after that cycle.
- Auto mode: ball_y and auto_en are sampled in the tick cycle, with no extra latency.
- Position changes by at most 2 per tick. A change of 0 occurs when saturated, or when req==NONE on that tick.
- rst assertion mid-tick aborts everything immediately. The first tick after deassertion falls STEP_DIV cycles later.

## Test plan
All scenarios use the defaults except STEP_DIV=4 and FAST_AFTER=3.
- Reset: hold rst=0, then release. Required: location_y_axis=6, at_top=1, draw_padle=0 and fast=0 until the first scan hit; first tick 4 cycles after release.
- Manual accelerate: hold btn_down. Required:
  - y goes 6→7→8→9 on ticks 1-3, then fast=1.
  - Subsequent ticks +2, stopping at 22 with at_bottom=1 and no overshoot.
- Opposing and reversal:
  - Press both buttons: y unchanged and state IDLE.
  - Hold btn_up from FAST: next tick −1 with fast=0.
- Auto tracking at y=6 (center 9) with auto_en=1:
  - ball_y=20: moves down.
  - ball_y=10: stays (deadband).
  - ball_y=3: moves up toward Y_MIN, saturating at 6.
- Draw window at y=10: required draw_padle=1 exactly for counter_x∈{0,1}, counter_y∈{10..15}, one cycle after each coordinate; 0 at counter_y=16 and counter_x=2.
- Async reset mid-move: pulse rst low while in FAST at y=18. Required: outputs at reset values immediately, without waiting for a clock edge.
